// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I sequencing FSM with memory-wait timeout
module multicycle_controller #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       CondTrue,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       InstrDone,
    output logic       IllegalOp,
    output logic       MemTimeout,
    output logic [3:0] State
);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEMADR   = 4'd3;
    localparam logic [3:0] S_MEMREAD  = 4'd4;
    localparam logic [3:0] S_MEMWB    = 4'd5;
    localparam logic [3:0] S_MEMWRITE = 4'd6;
    localparam logic [3:0] S_EXECR    = 4'd7;
    localparam logic [3:0] S_EXECI    = 4'd8;
    localparam logic [3:0] S_ALUWB    = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JAL      = 4'd11;
    localparam logic [3:0] S_JALR     = 4'd12;
    localparam logic [3:0] S_LUI      = 4'd13;
    localparam logic [3:0] S_TRAP     = 4'd15;

    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ill_q, ill_d;
    logic          mto_q, mto_d;
    logic          wait_st, tmo, rdy;

    assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    // On the timeout cycle the request is withdrawn, so a late MemReady is not honoured.
    assign tmo     = wait_st && (TIMEOUT != 0) && (cnt_q == TMO);
    assign rdy     = MemReady && !tmo;

    always_comb begin
        state_d = state_q;
        ill_d   = ill_q;
        mto_d   = mto_q || tmo;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    state_d = tmo ? S_TRAP : (rdy ? S_DECODE : S_FETCH);
            S_DECODE: begin
                case (op)
                    7'b0000011, 7'b0100011: state_d = S_MEMADR;
                    7'b0110011:             state_d = S_EXECR;
                    7'b0010011:             state_d = S_EXECI;
                    7'b1100011:             state_d = S_BRANCH;
                    7'b1101111:             state_d = S_JAL;
                    7'b1100111:             state_d = S_JALR;
                    7'b0110111:             state_d = S_LUI;
                    default: begin
                        state_d = S_TRAP;
                        ill_d   = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = (op == 7'b0000011) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = tmo ? S_TRAP : (rdy ? S_MEMWB : S_MEMREAD);
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = tmo ? S_TRAP : (rdy ? S_FETCH : S_MEMWRITE);
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_JAL;
            S_LUI:      state_d = S_FETCH;
            default:    state_d = S_TRAP;
        endcase
    end

    // Any state change clears the count, which covers entry to every wait state.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (wait_st && !MemReady && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
            mto_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
            mto_q   <= mto_d;
        end
    end

    always_comb begin
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemReq    = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        ImmSrc    = 3'b000;
        InstrDone = 1'b0;
        if (rst_n) begin
            case (op)
                7'b0100011: ImmSrc = 3'b001;
                7'b1100011: ImmSrc = 3'b010;
                7'b1101111: ImmSrc = 3'b011;
                7'b0110111: ImmSrc = 3'b100;
                default:    ImmSrc = 3'b000;
            endcase
            case (state_q)
                S_FETCH: begin
                    MemReq    = !tmo;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = rdy;
                    PCWrite   = rdy;
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                end
                S_MEMADR, S_JALR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                S_MEMREAD: begin
                    MemReq = !tmo;
                    AdrSrc = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                S_MEMWRITE: begin
                    MemReq    = !tmo;
                    MemWrite  = 1'b1;
                    AdrSrc    = 1'b1;
                    InstrDone = rdy;
                end
                S_EXECR: begin
                    ALUSrcA = 2'b10;
                    ALUOp   = 2'b10;
                end
                S_EXECI: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ALUOp   = 2'b10;
                end
                S_ALUWB, S_LUI: begin
                    ResultSrc = (state_q == S_LUI) ? 2'b11 : 2'b00;
                    RegWrite  = 1'b1;
                    InstrDone = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA   = 2'b10;
                    ALUOp     = 2'b01;
                    PCWrite   = CondTrue;
                    InstrDone = 1'b1;
                end
                S_JAL: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    PCWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign IllegalOp  = ill_q;
    assign MemTimeout = mto_q;
    assign State      = state_q;

endmodule
